// File: rtl/shifter_unit.sv
// shifter_unit: registered single-bit shifter (pass / LSL1 / LSR1 / ASR1).
// The operand is accepted when in_valid=1. The result appears one clock later
// with out_valid. All outputs come straight from flops.
// Optional status flags (carry_out, zero, neg) are present only when the
// SHIFTER_FLAGS_EN macro is defined.
module shifter_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       shift,
`ifdef SHIFTER_FLAGS_EN
   output logic             carry_out,
   output logic             zero,
   output logic             neg,
`endif
   output logic             out_valid,
   output logic [WIDTH-1:0] out
);

   localparam logic [1:0] OP_PASS = 2'b00;
   localparam logic [1:0] OP_LSL1 = 2'b01;
   localparam logic [1:0] OP_LSR1 = 2'b10;
   localparam logic [1:0] OP_ASR1 = 2'b11;

   // Shifted value for one operation; the distance is always exactly one bit.
   function automatic logic [WIDTH-1:0] shift_result(input logic [WIDTH-1:0] a,
                                                     input logic [1:0]       op);
      logic [WIDTH-1:0] r;
      case (op)
         OP_PASS: r = a;
         OP_LSL1: r = {a[WIDTH-2:0], 1'b0};
         OP_LSR1: r = {1'b0, a[WIDTH-1:1]};
         OP_ASR1: r = {a[WIDTH-1], a[WIDTH-1:1]};
         default: r = a;
      endcase
      return r;
   endfunction

`ifdef SHIFTER_FLAGS_EN
   // The bit that falls off the end; pass has no shifted-out bit.
   function automatic logic shift_carry(input logic [WIDTH-1:0] a,
                                        input logic [1:0]       op);
      logic c;
      case (op)
         OP_PASS: c = 1'b0;
         OP_LSL1: c = a[WIDTH-1];
         OP_LSR1: c = a[0];
         OP_ASR1: c = a[0];
         default: c = 1'b0;
      endcase
      return c;
   endfunction
`endif

   logic [WIDTH-1:0] result_s;
   logic [WIDTH-1:0] out_r;
   logic             out_valid_r;

   // Combinational shift of the presented operand. It is only consumed when
   // in_valid=1, so X values on an idle cycle never reach the registers.
   always_comb begin
      result_s = shift_result(in, shift);
   end

   // Result register. Reset has priority, and an idle cycle holds the data.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_r       <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
      end else if (in_valid) begin
         out_r       <= result_s;
         out_valid_r <= 1'b1;
      end else begin
         out_r       <= out_r;
         out_valid_r <= 1'b0;
      end
   end

   assign out       = out_r;
   assign out_valid = out_valid_r;

`ifdef SHIFTER_FLAGS_EN
   logic carry_s;
   logic carry_r;
   logic zero_r;
   logic neg_r;

   // Shifted-out bit for the presented operand.
   always_comb begin
      carry_s = shift_carry(in, shift);
   end

   // Flag registers share the enable and reset of the result register.
   // The flags are derived from the result, not from the operand.
   always_ff @(posedge clk) begin
      if (reset) begin
         carry_r <= 1'b0;
         zero_r  <= 1'b0;
         neg_r   <= 1'b0;
      end else if (in_valid) begin
         carry_r <= carry_s;
         zero_r  <= (result_s == {WIDTH{1'b0}});
         neg_r   <= result_s[WIDTH-1];
      end else begin
         carry_r <= carry_r;
         zero_r  <= zero_r;
         neg_r   <= neg_r;
      end
   end

   assign carry_out = carry_r;
   assign zero      = zero_r;
   assign neg       = neg_r;
`endif

endmodule

// File: tb/tb_shifter_unit.sv
// tb_shifter_unit: self-checking bench for shifter_unit (WIDTH=16).
// It runs a table of directed vectors, then hand-written corner sequences,
// then random traffic that is compared against an arithmetic reference model.
// Flag checks are compiled in only when SHIFTER_FLAGS_EN is defined.
module tb_shifter_unit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [15:0] in;
   logic [1:0]  shift;
   logic        out_valid;
   logic [15:0] out;
`ifdef SHIFTER_FLAGS_EN
   logic        carry_out;
   logic        zero;
   logic        neg;
`endif

   int tests;
   int fails;

   // Model state: the values the outputs should hold after the last edge.
   logic [15:0] m_out;
   logic        m_v;
   logic        m_c;
   logic        m_z;
   logic        m_n;

   shifter_unit #(.WIDTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in        (in),
      .shift     (shift),
`ifdef SHIFTER_FLAGS_EN
      .carry_out (carry_out),
      .zero      (zero),
      .neg       (neg),
`endif
      .out_valid (out_valid),
      .out       (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        v;
      logic [15:0] din;
      logic [1:0]  sh;
      logic [15:0] e_out;
      logic        e_v;
      logic        e_c;
      logic        e_z;
      logic        e_n;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [15:0] eo, input logic ev,
                            input logic ec, input logic ez, input logic en);
      check({name, ".out"}, {16'd0, out}, {16'd0, eo});
      check({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
`ifdef SHIFTER_FLAGS_EN
      check({name, ".carry_out"}, {31'd0, carry_out}, {31'd0, ec});
      check({name, ".zero"}, {31'd0, zero}, {31'd0, ez});
      check({name, ".neg"}, {31'd0, neg}, {31'd0, en});
`else
      if (ec === 1'bx || ez === 1'bx || en === 1'bx) $display("note: unknown flag expectation");
`endif
   endtask

   // Drive one cycle of inputs at the falling edge, then wait past the rising edge.
   task automatic drive(input logic r, input logic v, input logic [15:0] d, input logic [1:0] s);
      @(negedge clk);
      reset    = r;
      in_valid = v;
      in       = d;
      shift    = s;
      @(posedge clk);
      #1;
   endtask

   // Reference: returns {carry, result}, computed with integer arithmetic.
   function automatic logic [16:0] ref_op(input int x, input int s);
      int r;
      int c;
      case (s)
         0:       begin r = x;                                  c = 0;         end
         1:       begin r = (x * 2) % 65536;                    c = x / 32768; end
         2:       begin r = x / 2;                              c = x % 2;     end
         default: begin r = x / 2 + ((x >= 32768) ? 32768 : 0); c = x % 2;     end
      endcase
      return {c[0], r[15:0]};
   endfunction

   // Advance the model by one clock edge with the given inputs.
   task automatic model_step(input logic r, input logic v, input logic [15:0] d, input logic [1:0] s);
      logic [16:0] cr;
      if (r) begin
         m_out = 16'd0; m_v = 1'b0; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
      end else if (v) begin
         cr    = ref_op(int'(d), int'(s));
         m_out = cr[15:0];
         m_v   = 1'b1;
         m_c   = cr[16];
         m_z   = (cr[15:0] == 16'd0);
         m_n   = (cr[15:0] >= 16'h8000);
      end else begin
         m_v = 1'b0;
      end
   endtask

   task automatic model_cycle(input string name, input logic r, input logic v,
                              input logic [15:0] d, input logic [1:0] s);
      drive(r, v, d, s);
      model_step(r, v, d, s);
      check_all(name, m_out, m_v, m_c, m_z, m_n);
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in       = 16'h0000;
      shift    = 2'b00;

      //         rst   v     din       sh     e_out     e_v   c     z     n
      tbl[0]  = '{1'b1, 1'b1, 16'hFFFF, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 16'hFFFF, 2'b01, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 16'hFDC9, 2'b00, 16'hFDC9, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 16'hFDC9, 2'b01, 16'hFB92, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 16'hFDC9, 2'b10, 16'h7EE4, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 16'hFDC9, 2'b11, 16'hFEE4, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 16'h1234, 2'b01, 16'hFEE4, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 16'h0001, 2'b10, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 16'hFFFF, 2'b11, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 16'hFDC9, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 16'hFDC9, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].rst, tbl[i].v, tbl[i].din, tbl[i].sh);
         check_all($sformatf("tbl%0d", i), tbl[i].e_out, tbl[i].e_v,
                   tbl[i].e_c, tbl[i].e_z, tbl[i].e_n);
      end

      // Model starts in the reset state left behind by the table.
      m_out = 16'd0; m_v = 1'b0; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;

      // MSB boundary: ASR replicates the sign bit, LSL drops it into carry.
      drive(1'b0, 1'b1, 16'h8000, 2'b11);
      check_all("asr_8000", 16'hC000, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 16'h8000, 2'b01);
      check_all("lsl_8000", 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 16'h0000, 2'b00);
      check_all("pass_zero", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

      // Reset mid-stream: the in-flight operand is lost, then a new operand
      // at the first edge after reset is accepted immediately.
      drive(1'b0, 1'b1, 16'h00F0, 2'b10);
      check_all("mid_pre", 16'h0078, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 16'h7FFF, 2'b01);
      check_all("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 16'h7FFF, 2'b01);
      check_all("mid_post", 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);

      // Sync the model with the sequence above, then run random traffic.
      model_step(1'b0, 1'b1, 16'h7FFF, 2'b01);
      for (int k = 0; k < 400; k++) begin
         logic        r;
         logic        v;
         logic [15:0] d;
         logic [1:0]  s;
         r = ($urandom_range(0, 19) == 0);
         v = ($urandom_range(0, 3) != 0);
         d = 16'($urandom);
         if ($urandom_range(0, 7) == 0) d = 16'h8000;
         if ($urandom_range(0, 7) == 0) d = 16'h0001;
         s = 2'($urandom);
         model_cycle($sformatf("rnd%0d", k), r, v, d, s);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
